// File: rtl/ft245_device_port.sv
// FT245-style responder: presents RXF#/RD#/TXE#/WR# and a tri-state byte bus to an external host.
// Latency: read data on bus 3 edges after RD# falls; ingress push 3 edges after WR# falls.
// Backpressure: RXF#/TXE# gate the host; writes into a full ingress FIFO are dropped and flagged.
module ft245_device_port #(
   parameter int unsigned RECOVERY_CYCLES = 2
) (
   input  logic       clk_pll,
   input  logic       reset_n,
   inout  wire  [7:0] ft_data,
   output logic       ft_rxf_n,
   input  logic       ft_rd_n,
   output logic       ft_txe_n,
   input  logic       ft_wr_n,
   input  logic [7:0] egress_data,
   input  logic       egress_available,
   output logic       egress_pop,
   output logic [7:0] ingress_data,
   output logic       ingress_push,
   input  logic       ingress_full,
   output logic       err_overrun,
   output logic       err_underrun
);

   typedef enum logic [1:0] {IDLE, RD_DRIVE, WR_HOLD, RECOVER} state_t;

   state_t     state;
   state_t     state_nxt;

   logic       rd_s1, rd_s2;
   logic       wr_s1, wr_s2, wr_s3;
   logic [7:0] d1, d2, d3;
   logic [7:0] hold_reg;
   logic       oe;
   logic       rd_valid;
   logic [3:0] cnt;

   logic       rd_start, wr_edge, wr_start;
   logic       rd_done, wr_done, rec_done;
   logic       pop_nxt, push_nxt, ovr_set, und_set;
   logic       rxf_nxt, txe_nxt;

   // The bus is only ever driven while a valid read is in progress.
   assign ft_data = oe ? hold_reg : 8'bz;

   // Transfer detection from the synchronised strobes; read wins over a simultaneous write edge.
   assign rd_start = (state == IDLE) && !rd_s2;
   assign wr_edge  = !wr_s2 && wr_s3;
   assign wr_start = (state == IDLE) && wr_edge && !rd_start;
   assign rd_done  = (state == RD_DRIVE) && rd_s2;
   assign wr_done  = (state == WR_HOLD) && wr_s2;
   assign rec_done = (state == RECOVER) && (cnt == 4'd0);

   // State register.
   always_ff @(posedge clk_pll) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (rd_start)      state_nxt = RD_DRIVE;
            else if (wr_start) state_nxt = WR_HOLD;
         end
         RD_DRIVE: if (rd_done)  state_nxt = RECOVER;
         WR_HOLD:  if (wr_done)  state_nxt = RECOVER;
         RECOVER:  if (rec_done) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Output decisions; flags only track FIFO levels while idle with no transfer starting.
   always_comb begin
      pop_nxt  = rd_done && rd_valid;
      push_nxt = wr_start && !ingress_full;
      ovr_set  = (rd_start && wr_edge) || (wr_start && ingress_full);
      und_set  = rd_start && ft_rxf_n;
      rxf_nxt  = 1'b1;
      txe_nxt  = 1'b1;
      if ((state == IDLE) && !rd_start && !wr_start) begin
         rxf_nxt = !egress_available;
         txe_nxt = ingress_full;
      end
   end

   // Synchronisers, write-data pipeline, registered outputs and transfer bookkeeping.
   always_ff @(posedge clk_pll) begin
      if (!reset_n) begin
         rd_s1        <= 1'b1;
         rd_s2        <= 1'b1;
         wr_s1        <= 1'b1;
         wr_s2        <= 1'b1;
         wr_s3        <= 1'b1;
         d1           <= 8'h00;
         d2           <= 8'h00;
         d3           <= 8'h00;
         ft_rxf_n     <= 1'b1;
         ft_txe_n     <= 1'b1;
         egress_pop   <= 1'b0;
         ingress_push <= 1'b0;
         ingress_data <= 8'h00;
         hold_reg     <= 8'h00;
         oe           <= 1'b0;
         rd_valid     <= 1'b0;
         cnt          <= 4'd0;
         err_overrun  <= 1'b0;
         err_underrun <= 1'b0;
      end else begin
         rd_s1 <= ft_rd_n;
         rd_s2 <= rd_s1;
         wr_s1 <= ft_wr_n;
         wr_s2 <= wr_s1;
         wr_s3 <= wr_s2;
         // d3 lines up with wr_s3: it holds the sample from the last edge WR# was high.
         d1    <= ft_data;
         d2    <= d1;
         d3    <= d2;

         ft_rxf_n     <= rxf_nxt;
         ft_txe_n     <= txe_nxt;
         egress_pop   <= pop_nxt;
         ingress_push <= push_nxt;
         if (push_nxt) ingress_data <= d3;

         if (rd_start) begin
            hold_reg <= egress_data;
            oe       <= !ft_rxf_n;
            rd_valid <= !ft_rxf_n;
         end else if (rd_done) begin
            oe <= 1'b0;
         end

         if (rd_done || wr_done)                     cnt <= 4'(RECOVERY_CYCLES - 1);
         else if ((state == RECOVER) && (cnt != 4'd0)) cnt <= cnt - 4'd1;

         if (ovr_set) err_overrun  <= 1'b1;
         if (und_set) err_underrun <= 1'b1;
      end
   end

endmodule
